// File: rtl/cfb_stream_ctrl.sv
// cfb_stream_ctrl: AES-128 CFB-128 chaining controller driving an external block core
// over req/ack. It XORs each keystream block with one input block at a time.
module cfb_stream_ctrl #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [127:0]     key_in,
  input  logic [127:0]     iv_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             out_last,
  output logic             aes_req,
  output logic [127:0]     aes_key,
  output logic [127:0]     aes_blk,
  input  logic             aes_ack,
  input  logic [127:0]     aes_res,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_KS, S_IN, S_OUT} state_t;
  state_t           r_state, w_next;
  logic [127:0]     r_fb, r_key, r_ks, r_out;
  logic             r_mode, r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             w_start, w_ks_ld, w_in_acc, w_out_acc;
  logic [127:0]     w_xor;
  assign w_start   = (r_state == S_IDLE) && start;
  assign w_ks_ld   = (r_state == S_KS) && aes_ack;
  assign w_in_acc  = (r_state == S_IN) && in_valid;
  assign w_out_acc = (r_state == S_OUT) && out_ready;
  assign w_xor     = in_data ^ r_ks;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start     ? S_KS  : S_IDLE;
      S_KS:    w_next = aes_ack   ? S_IN  : S_KS;
      S_IN:    w_next = in_valid  ? S_OUT : S_IN;
      S_OUT:   w_next = out_ready ? (r_last ? S_IDLE : S_KS) : S_OUT;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    in_ready  = r_state == S_IN;
    out_valid = r_state == S_OUT;
    aes_req   = r_state == S_KS;
    busy      = r_state != S_IDLE;
    aes_key   = r_key;
    aes_blk   = r_fb;
    out_data  = r_out;
    out_last  = r_last;
    blk_cnt   = r_cnt;
  end
  // Feedback always takes the ciphertext side of the XOR, whichever direction runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fb   <= '0;
      r_key  <= '0;
      r_ks   <= '0;
      r_out  <= '0;
      r_mode <= 1'b0;
      r_last <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_start) begin
        r_fb   <= iv_in;
        r_key  <= key_in;
        r_mode <= mode;
        r_cnt  <= '0;
      end
      if (w_ks_ld) r_ks <= aes_res;
      if (w_in_acc) begin
        r_out  <= w_xor;
        r_last <= in_last;
        r_cnt  <= r_cnt + CNT_W'(1);
        r_fb   <= r_mode ? in_data : w_xor;
      end
    end
  end
endmodule

// File: tb/tb_cfb_stream_ctrl.sv
// tb_cfb_stream_ctrl: directed CFB-128 vectors against a behavioural AES-128 core
// answering the aes_* port with a random 0..5 cycle ack latency.
module tb_cfb_stream_ctrl;
  localparam logic [127:0] K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] P3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] P4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] C1 = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
  localparam logic [127:0] C2 = 128'hc8a64537a0b3a93fcde3cdad9f1ce58b;
  localparam logic [127:0] C3 = 128'h26751f67a3cbb140b1808cf187a4f4df;
  localparam logic [127:0] C4 = 128'hc04b05357c5d1c0eeac4c66f9ff7f2e6;
  logic clk = 0, rst_n = 0, start = 0, mode = 0, in_valid = 0, in_last = 0, out_ready = 0, aes_ack = 0;
  logic [127:0] key_in = '0, iv_in = '0, in_data = '0, aes_res = '0;
  logic in_ready, out_valid, out_last, aes_req, busy;
  logic [127:0] out_data, aes_key, aes_blk;
  logic [16:0] blk_cnt;
  int errors = 0, checks = 0, lat = 0;
  logic [7:0] sbox [256];
  cfb_stream_ctrl #(.CNT_W(17)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key_in(key_in), .iv_in(iv_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .aes_req(aes_req), .aes_key(aes_key), .aes_blk(aes_blk), .aes_ack(aes_ack), .aes_res(aes_res),
    .busy(busy), .blk_cnt(blk_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction
  task automatic build_sbox();
    logic [7:0] b, xv;
    for (int x = 0; x < 256; x++) begin
      xv = x[7:0];
      b = 8'h01;
      for (int j = 0; j < 254; j++) b = gm(b, xv);
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask
  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] blk);
    logic [7:0] s [16], t [16], k [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = blk[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int rn = 1; rn <= 10; rn++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int i = 0; i < 16; i++) t[i] = s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
      if (rn < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      k[0] = k[0] ^ sbox[k[13]] ^ rc;
      k[1] = k[1] ^ sbox[k[14]];
      k[2] = k[2] ^ sbox[k[15]];
      k[3] = k[3] ^ sbox[k[12]];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction
  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  // Behavioural AES core: answers each request after a fresh random latency.
  initial forever begin
    @(negedge clk);
    aes_ack = 1'b0;
    if (aes_req && rst_n) begin
      if (lat == 0) begin
        aes_res = aes_enc(aes_key, aes_blk);
        aes_ack = 1'b1;
        lat = $urandom_range(0, 5);
      end else lat--;
    end
  end
  always @(negedge clk)
    if (in_ready && out_valid) begin
      checks++; errors++;
      $display("FAIL ready_valid_overlap: in_ready=%b out_valid=%b want not both 1", in_ready, out_valid);
    end
  task automatic do_start(input logic m, input logic [127:0] k, input logic [127:0] iv);
    @(negedge clk);
    start = 1'b1; mode = m; key_in = k; iv_in = iv;
    @(negedge clk);
    start = 1'b0; key_in = '0; iv_in = '0;
  endtask
  task automatic push(input logic [127:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready=%b want 1 within 100 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic pull(output logic [127:0] o, output logic ol);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL pull_timeout: out_valid=%b want 1 within 100 cycles", out_valid);
    end
    o = out_data; ol = out_last;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic send(input logic [127:0] d, input logic l, output logic [127:0] o, output logic ol);
    push(d, l);
    pull(o, ol);
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({in_ready, out_valid, out_last, aes_req, busy} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {in_ready, out_valid, out_last, aes_req, busy}); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (blk_cnt !== '0) begin errors++; $display("FAIL reset_blk_cnt: got %0d want 0", blk_cnt); end
    checks++; if (aes_blk !== '0 || aes_key !== '0) begin errors++;
      $display("FAIL reset_fb_key: blk %h key %h want 0", aes_blk, aes_key); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_encrypt();
    logic [127:0] o;
    logic ol;
    do_start(1'b0, K, IV);
    checks++; if (busy !== 1'b1 || aes_req !== 1'b1) begin errors++;
      $display("FAIL enc_ks_entry: busy=%b aes_req=%b want 1 1", busy, aes_req); end
    checks++; if (aes_blk !== IV) begin errors++; $display("FAIL enc_iv_blk: got %h want %h", aes_blk, IV); end
    checks++; if (aes_key !== K) begin errors++; $display("FAIL enc_key: got %h want %h", aes_key, K); end
    push(P1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL enc_latency: out_valid=%b want 1", out_valid); end
    pull(o, ol);
    checks++; if (o !== C1) begin errors++; $display("FAIL enc_blk1: got %h want %h", o, C1); end
    checks++; if (blk_cnt !== 17'd1) begin errors++; $display("FAIL enc_cnt1: got %0d want 1", blk_cnt); end
    checks++; if (aes_req !== 1'b1 || aes_blk !== C1) begin errors++;
      $display("FAIL enc_feedback: req=%b blk %h want 1 %h", aes_req, aes_blk, C1); end
    send(P2, 1'b1, o, ol);
    checks++; if (o !== C2 || ol !== 1'b1) begin errors++;
      $display("FAIL enc_blk2: got %h last %b want %h 1", o, ol, C2); end
    checks++; if (busy !== 1'b0 || blk_cnt !== 17'd2) begin errors++;
      $display("FAIL enc_done: busy=%b cnt=%0d want 0 2", busy, blk_cnt); end
  endtask
  task automatic test_decrypt();
    logic [127:0] o;
    logic ol;
    do_start(1'b1, K, IV);
    send(C1, 1'b0, o, ol);
    checks++; if (o !== P1 || ol !== 1'b0) begin errors++;
      $display("FAIL dec_blk1: got %h last %b want %h 0", o, ol, P1); end
    checks++; if (aes_blk !== C1) begin errors++; $display("FAIL dec_feedback: got %h want %h", aes_blk, C1); end
    send(C2, 1'b1, o, ol);
    checks++; if (o !== P2 || ol !== 1'b1) begin errors++;
      $display("FAIL dec_blk2: got %h last %b want %h 1", o, ol, P2); end
    checks++; if (busy !== 1'b0 || blk_cnt !== 17'd2) begin errors++;
      $display("FAIL dec_done: busy=%b cnt=%0d want 0 2", busy, blk_cnt); end
  endtask
  task automatic test_backpressure();
    logic [127:0] o;
    logic ol;
    do_start(1'b0, K, IV);
    push(P1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== C1 || in_ready !== 1'b0 || aes_req !== 1'b0) begin errors++;
        $display("FAIL bp_hold%0d: valid=%b data %h in_ready=%b req=%b want 1 %h 0 0",
                 i, out_valid, out_data, in_ready, aes_req, C1); end
      @(negedge clk);
    end
    pull(o, ol);
    checks++; if (o !== C1) begin errors++; $display("FAIL bp_blk1: got %h want %h", o, C1); end
    send(P2, 1'b0, o, ol);
    checks++; if (o !== C2) begin errors++; $display("FAIL bp_blk2: got %h want %h", o, C2); end
    send(P3, 1'b0, o, ol);
    checks++; if (o !== C3) begin errors++; $display("FAIL bp_blk3: got %h want %h", o, C3); end
    send(P4, 1'b1, o, ol);
    checks++; if (o !== C4 || ol !== 1'b1) begin errors++;
      $display("FAIL bp_blk4: got %h last %b want %h 1", o, ol, C4); end
    checks++; if (blk_cnt !== 17'd4 || busy !== 1'b0) begin errors++;
      $display("FAIL bp_done: cnt=%0d busy=%b want 4 0", blk_cnt, busy); end
  endtask
  task automatic test_mid_reset();
    logic [127:0] o;
    logic ol;
    do_start(1'b0, K, IV);
    send(P1, 1'b0, o, ol);
    send(P2, 1'b0, o, ol);
    checks++; if (aes_req !== 1'b1) begin errors++; $display("FAIL mr_in_ks: aes_req=%b want 1", aes_req); end
    rst_n = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid, out_last, aes_req, busy} !== 5'b0 || blk_cnt !== '0) begin errors++;
      $display("FAIL mr_ctrl: got %b cnt %0d want 00000 0", {in_ready, out_valid, out_last, aes_req, busy}, blk_cnt); end
    checks++; if (out_data !== '0 || aes_blk !== '0 || aes_key !== '0) begin errors++;
      $display("FAIL mr_data: out %h blk %h key %h want 0", out_data, aes_blk, aes_key); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL mr_idle: out_valid=%b busy=%b want 0 0", out_valid, busy); end
    do_start(1'b0, K, IV);
    send(P1, 1'b1, o, ol);
    checks++; if (o !== C1 || blk_cnt !== 17'd1) begin errors++;
      $display("FAIL mr_restart: got %h cnt %0d want %h 1", o, blk_cnt, C1); end
  endtask
  task automatic test_start_ignored();
    logic [127:0] o;
    logic ol;
    do_start(1'b0, K, IV);
    send(P1, 1'b0, o, ol);
    start = 1'b1; mode = 1'b1; key_in = ~K; iv_in = rnd();
    @(negedge clk);
    start = 1'b0;
    checks++; if (aes_key !== K || busy !== 1'b1) begin errors++;
      $display("FAIL si_key: got %h busy %b want %h 1", aes_key, busy, K); end
    send(P2, 1'b1, o, ol);
    checks++; if (o !== C2 || blk_cnt !== 17'd2) begin errors++;
      $display("FAIL si_blk2: got %h cnt %0d want %h 2", o, blk_cnt, C2); end
    mode = 1'b0;
  endtask
  task automatic test_round_trip();
    logic [127:0] k, iv, fb, o;
    logic [127:0] p [40], c [40];
    logic ol;
    k = rnd(); iv = rnd(); fb = iv;
    do_start(1'b0, k, iv);
    for (int i = 0; i < 40; i++) begin
      p[i] = rnd();
      c[i] = p[i] ^ aes_enc(k, fb);
      fb = c[i];
      send(p[i], i == 39, o, ol);
      checks++; if (o !== c[i]) begin errors++; $display("FAIL rt_enc%0d: got %h want %h", i, o, c[i]); end
    end
    checks++; if (blk_cnt !== 17'd40) begin errors++; $display("FAIL rt_enc_cnt: got %0d want 40", blk_cnt); end
    do_start(1'b1, k, iv);
    for (int i = 0; i < 40; i++) begin
      send(c[i], i == 39, o, ol);
      checks++; if (o !== p[i]) begin errors++; $display("FAIL rt_dec%0d: got %h want %h", i, o, p[i]); end
    end
    checks++; if (blk_cnt !== 17'd40 || busy !== 1'b0 || ol !== 1'b1) begin errors++;
      $display("FAIL rt_dec_done: cnt %0d busy %b last %b want 40 0 1", blk_cnt, busy, ol); end
  endtask
  initial begin
    build_sbox();
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_mid_reset();
    test_start_ignored();
    test_round_trip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1, "watchdog");
  end
endmodule
